// File: rtl/k503_line_scanner.sv
// Per-scanline object Y-hit scanner: walks the object table once per line and
// queues index/row/flip of every 503-style Y hit into a small FIFO for the renderer.
module k503_line_scanner #(
    parameter int unsigned NUM_OBJ   = 64,
    parameter int unsigned MAX_HITS  = 8,
    parameter int unsigned SPR_HBITS = 4,
    localparam int unsigned AW = $clog2(NUM_OBJ),
    localparam int unsigned PW = $clog2(MAX_HITS),
    localparam int unsigned CW = PW + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cen_i,
    input  logic                 line_start_i,
    input  logic [7:0]           vcnt_i,
    output logic [AW-1:0]        obj_addr_o,
    input  logic [7:0]           obj_y_i,
    input  logic                 obj_flipx_i,
    input  logic                 obj_flipy_i,
    output logic                 hit_valid_o,
    input  logic                 hit_rd_i,
    output logic [AW-1:0]        hit_idx_o,
    output logic [SPR_HBITS-1:0] hit_row_o,
    output logic                 hit_flipx_o,
    output logic [CW-1:0]        hit_count_o,
    output logic                 busy_o,
    output logic                 overflow_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_LAST = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    vcnt_q, vcnt_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [AW-1:0]        idx_mem [MAX_HITS];
    logic [SPR_HBITS-1:0] row_mem [MAX_HITS];
    logic                 fx_mem  [MAX_HITS];

    logic [7:0]           sum;
    logic                 is_hit;
    logic [SPR_HBITS-1:0] row;
    logic [AW-1:0]        eval_idx;
    logic                 eval_en;
    logic                 pop;
    logic                 full;
    logic                 push;

    always_comb begin
        sum      = obj_y_i + vcnt_q;
        is_hit   = &sum[7:SPR_HBITS];
        row      = sum[SPR_HBITS-1:0] ^ {SPR_HBITS{obj_flipy_i}};
        // Data on obj_y_i belongs to the address presented one cen cycle earlier.
        eval_idx = (state_q == ST_LAST) ? addr_q : addr_q - 1'b1;
        eval_en  = ((state_q == ST_SCAN) && (addr_q != '0)) || (state_q == ST_LAST);
        pop      = hit_rd_i && (count_q != '0);
        full     = (count_q == CW'(MAX_HITS));
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        vcnt_d  = vcnt_q;
        busy_d  = busy_q;
        ovf_d   = ovf_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        push    = 1'b0;
        if (cen_i) begin
            if (line_start_i) begin
                state_d = ST_SCAN;
                addr_d  = '0;
                vcnt_d  = vcnt_i;
                busy_d  = 1'b1;
                ovf_d   = 1'b0;
                wptr_d  = '0;
                rptr_d  = '0;
                count_d = '0;
            end else begin
                if (pop) begin
                    rptr_d = rptr_q + 1'b1;
                end
                case (state_q)
                    ST_SCAN: begin
                        if (addr_q == AW'(NUM_OBJ - 1)) begin
                            state_d = ST_LAST;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                    ST_LAST: begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        addr_d  = '0;
                    end
                    default: ;
                endcase
                if (eval_en && is_hit) begin
                    if (!full || pop) begin
                        push   = 1'b1;
                        wptr_d = wptr_q + 1'b1;
                    end else begin
                        // A dropped hit ends the scan for this line.
                        ovf_d   = 1'b1;
                        busy_d  = 1'b0;
                        addr_d  = '0;
                        state_d = ST_IDLE;
                    end
                end
                count_d = count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            vcnt_q  <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            vcnt_q  <= vcnt_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            idx_mem[wptr_q] <= eval_idx;
            row_mem[wptr_q] <= row;
            fx_mem[wptr_q]  <= obj_flipx_i;
        end
    end

    assign obj_addr_o  = addr_q;
    assign hit_valid_o = (count_q != '0);
    assign hit_idx_o   = hit_valid_o ? idx_mem[rptr_q] : '0;
    assign hit_row_o   = hit_valid_o ? row_mem[rptr_q] : '0;
    assign hit_flipx_o = hit_valid_o ? fx_mem[rptr_q] : 1'b0;
    assign hit_count_o = count_q;
    assign busy_o      = busy_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_k503_line_scanner.sv
// Bench for k503_line_scanner: directed and random lines checked against a
// list-of-hits model computed from the Y-hit rule with plain arithmetic.
module tb_k503_line_scanner;

    localparam int NO = 64;
    localparam int MH = 8;
    localparam int SH = 4;
    localparam int AW = 6;
    localparam int CW = 4;
    localparam int H  = 16;

    logic          clk = 1'b0;
    logic          reset, cen, line_start, hit_rd;
    logic [7:0]    vcnt;
    logic [AW-1:0] obj_addr, hit_idx;
    logic [7:0]    obj_y = 8'd0;
    logic          obj_flipx = 1'b0, obj_flipy = 1'b0;
    logic          hit_valid, hit_flipx, busy, overflow;
    logic [SH-1:0] hit_row;
    logic [CW-1:0] hit_count;

    logic [7:0] tab_y  [NO];
    logic       tab_fx [NO];
    logic       tab_fy [NO];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [7:0] idx;
        logic [7:0] row;
        logic       fx;
    } hit_t;

    hit_t exp_q[$];
    hit_t got_q[$];

    k503_line_scanner #(.NUM_OBJ(NO), .MAX_HITS(MH), .SPR_HBITS(SH)) dut (
        .clk          (clk),
        .reset        (reset),
        .cen_i        (cen),
        .line_start_i (line_start),
        .vcnt_i       (vcnt),
        .obj_addr_o   (obj_addr),
        .obj_y_i      (obj_y),
        .obj_flipx_i  (obj_flipx),
        .obj_flipy_i  (obj_flipy),
        .hit_valid_o  (hit_valid),
        .hit_rd_i     (hit_rd),
        .hit_idx_o    (hit_idx),
        .hit_row_o    (hit_row),
        .hit_flipx_o  (hit_flipx),
        .hit_count_o  (hit_count),
        .busy_o       (busy),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    // Object RAM: registered read, one cen cycle of latency.
    always @(posedge clk) begin
        if (cen) begin
            obj_y     <= tab_y[obj_addr];
            obj_flipx <= tab_fx[obj_addr];
            obj_flipy <= tab_fy[obj_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_table();
        for (int i = 0; i < NO; i++) begin
            tab_y[i]  = 8'h00;
            tab_fx[i] = 1'b0;
            tab_fy[i] = 1'b0;
        end
    endtask

    // A hit is a sum landing in the top H values of the byte; row counts down when flipped.
    task automatic model(input logic [7:0] v);
        int s, r;
        exp_q.delete();
        for (int k = 0; k < NO; k++) begin
            s = (int'(tab_y[k]) + int'(v)) % 256;
            if (s >= 256 - H) begin
                r = s % H;
                if (tab_fy[k]) r = H - 1 - r;
                exp_q.push_back(hit_t'{8'(k), 8'(r), tab_fx[k]});
            end
        end
    endtask

    task automatic run_line(input logic [7:0] v, input bit popm, input bit rcen, input string tag);
        int c, guard, maxc, nexp, nkeep, expfall;
        bit expovf;
        logic [AW-1:0] a0;
        model(v);
        got_q.delete();
        cen = 1'b1;
        hit_rd = 1'b0;
        vcnt = v;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        check({tag, "_start_busy"}, busy, 1);
        check({tag, "_start_addr"}, obj_addr, 0);
        check({tag, "_start_cnt"}, hit_count, 0);
        check({tag, "_start_ovf"}, overflow, 0);
        c = 0;
        guard = 0;
        maxc = 0;
        while (busy && guard < 3000) begin
            cen = rcen ? 1'($urandom_range(0, 1)) : 1'b1;
            hit_rd = popm;
            if (cen && popm && hit_valid) got_q.push_back(hit_t'{8'(hit_idx), 8'(hit_row), hit_flipx});
            a0 = obj_addr;
            tick();
            guard++;
            if (cen) c++;
            else check({tag, "_freeze_addr"}, obj_addr, a0);
            if (int'(hit_count) > maxc) maxc = int'(hit_count);
        end
        cen = 1'b1;
        check({tag, "_scan_done"}, busy, 0);
        nexp = exp_q.size();
        if (!popm && nexp > MH) begin
            expovf = 1'b1;
            expfall = int'(exp_q[MH].idx) + 2;
            nkeep = MH;
        end else begin
            expovf = 1'b0;
            expfall = NO + 1;
            nkeep = nexp;
        end
        check({tag, "_busy_cycles"}, c, expfall);
        check({tag, "_overflow"}, overflow, expovf);
        if (!popm) check({tag, "_count"}, hit_count, nkeep);
        else check({tag, "_maxcount_le1"}, maxc <= 1, 1);
        hit_rd = 1'b1;
        guard = 0;
        while (hit_valid && guard < 100) begin
            got_q.push_back(hit_t'{8'(hit_idx), 8'(hit_row), hit_flipx});
            tick();
            guard++;
        end
        hit_rd = 1'b0;
        check({tag, "_nhits"}, got_q.size(), nkeep);
        for (int i = 0; i < nkeep && i < got_q.size(); i++) begin
            check($sformatf("%s_idx%0d", tag, i), got_q[i].idx, exp_q[i].idx);
            check($sformatf("%s_row%0d", tag, i), got_q[i].row, exp_q[i].row);
            check($sformatf("%s_fx%0d", tag, i), got_q[i].fx, exp_q[i].fx);
        end
        check({tag, "_empty"}, hit_valid, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_addr"}, obj_addr, 0);
        check({tag, "_cnt"}, hit_count, 0);
        check({tag, "_valid"}, hit_valid, 0);
        check({tag, "_idx"}, hit_idx, 0);
        check({tag, "_row"}, hit_row, 0);
        check({tag, "_fx"}, hit_flipx, 0);
        check({tag, "_ovf"}, overflow, 0);
    endtask

    initial begin
        reset = 1'b1;
        cen = 1'b1;
        line_start = 1'b0;
        hit_rd = 1'b0;
        vcnt = 8'h00;
        clear_table();
        tick();
        tick();
        check_zero_outputs("reset");
        reset = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        tab_y[3] = 8'hE5;
        run_line(8'h10, 1'b0, 1'b0, "basic");
        if (got_q.size() > 0) begin
            check("basic_idx3", got_q[0].idx, 3);
            check("basic_row5", got_q[0].row, 5);
        end

        tab_fy[3] = 1'b1;
        run_line(8'h10, 1'b0, 1'b0, "flip");
        if (got_q.size() > 0) check("flip_rowA", got_q[0].row, 10);

        tab_fy[3] = 1'b0;
        tab_y[3] = 8'hD5;
        run_line(8'h10, 1'b0, 1'b0, "miss");

        clear_table();
        tab_y[3] = 8'hDF;
        tab_y[4] = 8'hE0;
        run_line(8'h20, 1'b0, 1'b0, "wrap");
        if (got_q.size() > 0) check("wrap_rowF", got_q[0].row, 15);

        clear_table();
        for (int i = 0; i < 12; i++) tab_y[i] = 8'hE5;
        run_line(8'h10, 1'b0, 1'b0, "ovf");

        clear_table();
        for (int i = 0; i < 10; i++) begin
            tab_y[i] = 8'hE0 + 8'(i);
            tab_fx[i] = 1'(i % 2);
        end
        run_line(8'h10, 1'b1, 1'b0, "pop");

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NO; i++) begin
                tab_y[i] = 8'($urandom_range(0, 255));
                tab_fx[i] = 1'($urandom_range(0, 1));
                tab_fy[i] = 1'($urandom_range(0, 1));
            end
            run_line(8'($urandom_range(0, 255)), r[0], r >= 3, $sformatf("rand%0d", r));
        end

        clear_table();
        for (int i = 0; i < 6; i++) tab_y[i] = 8'hE5;
        tab_y[10] = 8'hDF;
        vcnt = 8'h10;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (20) tick();
        check("restart_pre_cnt", hit_count, 6);
        run_line(8'h20, 1'b0, 1'b0, "restart");

        vcnt = 8'h20;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (20) tick();
        check("midrst_pre_busy", busy, 1);
        #2 reset = 1'b1;
        #1 check_zero_outputs("midrst");
        #1 reset = 1'b0;
        repeat (10) tick();
        check_zero_outputs("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/k503_line_scanner.md
Name: k503_line_scanner

Overview:
- Clocked, parametrised successor to the 503 sprite-row logic.
- On each scanline start it walks the whole object table and applies the 503-style Y-hit test to every entry. The test is the 8-bit sum of object Y and VCNT, with all upper sum bits set.
- For each hit it produces a row address with vertical flip applied, and queues index/row/flip into a small hit FIFO.
- Sits between object RAM and the sprite line-buffer renderer, which pops hits during the line.

Parameters:
- NUM_OBJ, 64: object entries scanned per line (power of 2, 2..256).
- MAX_HITS, 8: hit FIFO depth, i.e. sprites per line (power of 2, 2..32).
- SPR_HBITS, 4: log2 sprite height (4 = 16 lines, 5 = 32 lines).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- cen, in, 1: clock enable; all state advances only when cen=1.
- line_start, in, 1: scanline start strobe, sampled when cen=1.
- vcnt, in, 8: vertical counter, latched at line_start.
- obj_addr, out, clog2(NUM_OBJ): object RAM entry address.
- obj_y, in, 8: Y byte of the entry, valid 1 cen cycle after obj_addr.
- obj_flipx, in, 1: attribute bit, same timing as obj_y.
- obj_flipy, in, 1: attribute bit, same timing as obj_y.
- hit_valid, out, 1: FIFO non-empty.
- hit_rd, in, 1: pop the head entry; honoured only when cen=1 and hit_valid=1.
- hit_idx, out, clog2(NUM_OBJ): head entry's object index.
- hit_row, out, SPR_HBITS: head entry's flipped row.
- hit_flipx, out, 1: head entry's horizontal flip.
- hit_count, out, clog2(MAX_HITS)+1: entries in the FIFO.
- busy, out, 1: scan in progress.
- overflow, out, 1: sticky per line; set when a hit was dropped because the FIFO was full.

Behaviour:
- Interface fixed: one clock `clk`; `reset` asynchronous, active-high.
- Reset values:
  - state IDLE;
  - obj_addr, hit_count, busy, overflow = 0;
  - hit_valid = 0;
  - hit_idx, hit_row, hit_flipx = 0.
- Hit test, for entry k:
  - sum = (obj_y + vcnt_lat) mod 256;
  - hit iff sum[7:SPR_HBITS] is all ones;
  - hit_row = sum[SPR_HBITS-1:0] XOR {SPR_HBITS{obj_flipy}}.
- FSM has states IDLE, SCAN, LAST:
  - IDLE: on line_start, latch vcnt, flush FIFO (count=0), clear overflow, set obj_addr=0 and busy=1, go to SCAN.
  - SCAN: each cen cycle, evaluate the data for address obj_addr-1 (none on the first cycle), then increment obj_addr. When obj_addr==NUM_OBJ-1 has been presented, go to LAST.
  - LAST: evaluate entry NUM_OBJ-1, set busy=0, obj_addr=0, go to IDLE.
  - A full scan takes NUM_OBJ+1 cen cycles from line_start.
- Push rules:
  - A hit is pushed when hit_count<MAX_HITS or a pop occurs in the same cycle.
  - Otherwise the hit is dropped, overflow=1, and the scan aborts: busy=0, go to IDLE.
- Ordering and timing:
  - Entries are queued in ascending index order.
  - An entry is readable on hit_* the cen cycle after its push.
  - The FIFO pointers wrap modulo MAX_HITS.
- Simultaneous push and pop: hit_count is unchanged, and the head advances correctly.
- line_start while busy: abort the current scan and restart exactly as from IDLE. Unread hits are discarded and vcnt is re-latched.
- hit_rd with an empty FIFO is ignored.
- cen=0 freezes all state. Outputs hold.
- Reset asserted mid-scan forces the reset values immediately. Nothing resumes after reset until the next line_start.

Test Plan:
- Basic hit (SPR_HBITS=4): vcnt=0x10; entry 3 obj_y=0xE5, flipy=0; all other entries 0x00.
  - Expect exactly 1 hit: idx=3, row=5.
  - busy falls after 65 cen cycles.
- Flip/miss: entry 3 flipy=1 gives row=0xA; entry 3 obj_y=0xD5 (sum 0xE5) gives no hit and hit_valid stays 0.
- Wrap boundary: vcnt=0x20; obj_y=0xDF (sum 0xFF) hits with row=0xF; obj_y=0xE0 (sum 0x00) misses.
- Overflow (MAX_HITS=8): 12 hitting entries at idx 0..11 with no pops.
  - Expect 8 entries, idx 0..7.
  - overflow=1 on evaluation of idx 8; busy falls then.
  - The next line_start clears overflow.
- Concurrent pop: 10 hits with hit_rd held high from the first hit_valid.
  - Expect all 10 popped in order, overflow=0, hit_count≤1 throughout.
- Restart/reset: line_start issued at scan cycle 20 restarts with obj_addr=0 and count=0; reset pulsed mid-scan gives all outputs 0 and idle until the next line_start.
